load_store_unit: RTL

- CPU-side initiator for the data memory: it takes one load or store request from the execute stage and issues word-granular accesses to the data memory port.
- Handles byte lane steering and write strobes, and splits misaligned accesses that cross a word boundary into two word accesses.
- Sign/zero-extends load data and returns a single response per request.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 46 ++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and decode helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_DW    = 32;
  localparam int unsigned LSU_LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    WAIT,
    DONE
  } lsu_state_t;

  // Access size in bytes; 0 marks an encoding with no defined size.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = 3'd1;
      F3_H, F3_HU: f3_size = 3'd2;
      F3_W:        f3_size = 3'd4;
      default:     f3_size = 3'd0;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    f3_legal = (f3_size(f3) != 3'd0);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/data across two words, load shift and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]          off_i,
  input  logic [2:0]          size_i,
  input  logic [LSU_DW-1:0]   wdata_i,
  input  logic [LSU_DW-1:0]   word0_i,
  input  logic [LSU_DW-1:0]   word1_i,
  input  logic                is_unsigned_i,
  output logic [LSU_LANES-1:0] strb0_o,
  output logic [LSU_LANES-1:0] strb1_o,
  output logic [LSU_DW-1:0]   wdata0_o,
  output logic [LSU_DW-1:0]   wdata1_o,
  output logic [LSU_DW-1:0]   rdata_o
);

  logic [5:0]          shamt;
  logic [7:0]          mask8;
  logic [7:0]          strb8;
  logic [63:0]         wdata64;
  logic [LSU_DW-1:0]   rsh;

  always_comb begin
    shamt = {off_i, 3'b000};
    case (size_i)
      3'd1:    mask8 = 8'h01;
      3'd2:    mask8 = 8'h03;
      3'd4:    mask8 = 8'h0F;
      default: mask8 = 8'h00;
    endcase
    strb8   = mask8 << off_i;
    wdata64 = {32'b0, wdata_i} << shamt;
    rsh     = 32'({word1_i, word0_i} >> shamt);
    strb0_o  = strb8[3:0];
    strb1_o  = strb8[7:4];
    wdata0_o = wdata64[31:0];
    wdata1_o = wdata64[63:32];
    case (size_i)
      3'd1:    rdata_o = is_unsigned_i ? {24'b0, rsh[7:0]}  : {{24{rsh[7]}}, rsh[7:0]};
      3'd2:    rdata_o = is_unsigned_i ? {16'b0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
      default: rdata_o = rsh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one request at a time, word accesses to a synchronous-read memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDRESS_WIDTH    = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-3:0] mem_addr,
  output logic [3:0]               mem_wstrb,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam int unsigned WAW = ADDRESS_WIDTH - 2;

  lsu_state_t               state_q, state_d;
  logic                     we_q, we_d;
  logic [2:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     err_q, err_d;
  logic                     split_q, split_d;
  logic [DATA_WIDTH-1:0]    word0_q, word0_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

  logic [2:0]               req_size;
  logic                     req_split, req_mis, req_err;
  logic [3:0]               strb0, strb1;
  logic [DATA_WIDTH-1:0]    wdata0, wdata1, align_w0, align_w1, align_rdata;
  logic [WAW-1:0]           waddr0;
  logic                     acc0, acc1;

  // Request classification, only consumed when a request is latched in IDLE.
  always_comb begin
    req_size  = f3_size(req_funct3);
    req_split = (4'(req_addr[1:0]) + 4'(req_size)) > 4'd4;
    req_mis   = (req_addr[1:0] & 2'(req_size - 3'd1)) != 2'b00;
    req_err   = !f3_legal(req_we, req_funct3) || (!ALLOW_MISALIGNED && req_mis);
  end

  // The final word arrives on mem_rdata in WAIT; word0 was captured earlier when split.
  assign align_w0 = split_q ? word0_q : mem_rdata;
  assign align_w1 = split_q ? mem_rdata : '0;

  lsu_align u_align (
    .off_i         (addr_q[1:0]),
    .size_i        (size_q),
    .wdata_i       (wdata_q),
    .word0_i       (align_w0),
    .word1_i       (align_w1),
    .is_unsigned_i (uns_q),
    .strb0_o       (strb0),
    .strb1_o       (strb1),
    .wdata0_o      (wdata0),
    .wdata1_o      (wdata1),
    .rdata_o       (align_rdata)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    split_d = split_q;
    word0_d = word0_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_funct3[2];
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_err;
          split_d = req_split && !req_err;
          word0_d = '0;
          rdata_d = '0;
          state_d = req_err ? DONE : ACC0;
        end
      end
      ACC0:    state_d = split_q ? ACC1 : (we_q ? DONE : WAIT);
      ACC1: begin
        if (!we_q) word0_d = mem_rdata;
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        rdata_d = align_rdata;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      word0_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      split_q <= split_d;
      word0_q <= word0_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory and response outputs decode from the state and latched request only.
  assign acc0   = (state_q == ACC0);
  assign acc1   = (state_q == ACC1);
  assign waddr0 = addr_q[ADDRESS_WIDTH-1:2];

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_err   = (state_q == DONE) && err_q;
  assign resp_rdata = (state_q == DONE) ? rdata_q : '0;

  assign mem_req   = acc0 || acc1;
  assign mem_we    = (acc0 || acc1) && we_q;
  assign mem_addr  = acc0 ? waddr0 : (acc1 ? waddr0 + WAW'(1) : '0);
  assign mem_wstrb = (acc0 && we_q) ? strb0 : ((acc1 && we_q) ? strb1 : 4'b0000);
  assign mem_wdata = (acc0 && we_q) ? wdata0 : ((acc1 && we_q) ? wdata1 : '0);

endmodule
